// File: rtl/utopia1_tx_sched.sv
//------------------------------------------------------------------------------
// utopia1_tx_sched
//
// Cell-level round-robin scheduler sharing one Utopia level 1 ATM-layer
// transmit port among N_PORTS cell sources. A source raises req once it holds
// a complete 53-byte cell. When the PHY reports cell space (tx_clav) the
// scheduler grants one eligible source, streams that cell byte by byte onto
// the Tx pins and pulses cell_done to the source as the last byte goes out.
//
// Ports:
//   clk        Tx clock, all logic on the rising edge
//   reset_n    asynchronous active-low reset
//   req        per-port "full cell ready" level request
//   port_en    per-port enable mask; a disabled port never wins
//   cell_byte  per-port byte at byte_idx, port p on bits [8p+7:8p]
//   gnt        one-hot grant, held for the whole cell
//   byte_idx   byte index 0..52 being read from the granted port
//   cell_done  one-cycle pulse to the winner with its last byte
//   tx_data    Utopia Tx data
//   tx_soc     Utopia start-of-cell, high with byte 0
//   tx_en_n    Utopia Tx enable, active low
//   tx_clav    PHY cell-available, only looked at between cells
//   cell_cnt   cells sent since reset, wraps silently
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module utopia1_tx_sched #(
    parameter int N_PORTS = 4,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_PORTS-1:0]     req,
    input  logic [N_PORTS-1:0]     port_en,
    input  logic [8*N_PORTS-1:0]   cell_byte,
    output logic [N_PORTS-1:0]     gnt,
    output logic [5:0]             byte_idx,
    output logic [N_PORTS-1:0]     cell_done,
    output logic [7:0]             tx_data,
    output logic                   tx_soc,
    output logic                   tx_en_n,
    input  logic                   tx_clav,
    output logic [CNT_W-1:0]       cell_cnt
);

    localparam int         IDX_W     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [5:0] LAST_BYTE = 6'd52;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               r_state;
    logic [IDX_W-1:0]     r_rr;
    logic [N_PORTS-1:0]   r_gnt;
    logic [N_PORTS-1:0]   r_cellDone;
    logic [5:0]           r_byteIdx;
    logic [7:0]           r_txData;
    logic                 r_txSoc;
    logic                 r_txEnN;
    logic [CNT_W-1:0]     r_cellCnt;

    logic [N_PORTS-1:0]   w_elig;
    logic                 w_found;
    logic [IDX_W-1:0]     w_winner;
    logic [7:0]           w_byte;

    // Wraps an arbitrary non-negative offset onto a legal port index.
    function automatic logic [IDX_W-1:0] wrapIdx(input int v);
        return IDX_W'(v % N_PORTS);
    endfunction

    assign w_elig = req & port_en;

    // r_rr holds the most recent winner, so searching from r_rr+1 upward gives
    // the port after the last one served first refusal. While a cell is in
    // flight r_rr is also the index of the port being read.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_rr;
        for (int k = 1; k <= N_PORTS; k++) begin
            if (!w_found && w_elig[wrapIdx(int'(r_rr) + k)]) begin
                w_found  = 1'b1;
                w_winner = wrapIdx(int'(r_rr) + k);
            end
        end
    end

    // Byte lane of the port currently being sent.
    assign w_byte = cell_byte[{r_rr, 3'b000} +: 8];

    // Two-state cell engine. IDLE waits for PHY space plus an eligible request;
    // SEND pushes 53 bytes unconditionally, since Utopia 1 flow control is per
    // cell and clav/req changes mid-cell must not stall or truncate it. Leaving
    // SEND always passes through IDLE, which guarantees an idle clock between
    // cells on the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rr       <= IDX_W'(N_PORTS - 1);
            r_gnt      <= '0;
            r_cellDone <= '0;
            r_byteIdx  <= '0;
            r_txData   <= 8'h00;
            r_txSoc    <= 1'b0;
            r_txEnN    <= 1'b1;
            r_cellCnt  <= '0;
        end else begin
            r_cellDone <= '0;
            case (r_state)
                IDLE: begin
                    r_txEnN <= 1'b1;
                    r_txSoc <= 1'b0;
                    if (tx_clav && w_found) begin
                        r_gnt     <= {{(N_PORTS-1){1'b0}}, 1'b1} << w_winner;
                        r_byteIdx <= '0;
                        r_rr      <= w_winner;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    r_txData <= w_byte;
                    r_txEnN  <= 1'b0;
                    r_txSoc  <= (r_byteIdx == 6'd0);
                    if (r_byteIdx == LAST_BYTE) begin
                        r_cellDone <= r_gnt;
                        r_cellCnt  <= r_cellCnt + CNT_W'(1);
                        r_gnt      <= '0;
                        r_byteIdx  <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_byteIdx <= r_byteIdx + 6'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign byte_idx  = r_byteIdx;
    assign cell_done = r_cellDone;
    assign tx_data   = r_txData;
    assign tx_soc    = r_txSoc;
    assign tx_en_n   = r_txEnN;
    assign cell_cnt  = r_cellCnt;

endmodule

// File: tb/tb_utopia1_tx_sched.sv
//------------------------------------------------------------------------------
// tb_utopia1_tx_sched
//
// Bench for the Utopia 1 Tx round-robin scheduler. Two instances share all
// inputs: the default 16-bit counter build and a 2-bit counter build used for
// the wrap sequence. A pin monitor rebuilds every cell from tx_soc/tx_en_n and
// checks it against a cell-level round-robin model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_utopia1_tx_sched;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req;
    logic [3:0]  portEn;
    logic [31:0] cellByte;
    logic [31:0] cellByte2;
    logic        tx_clav;

    logic [3:0]  gnt,      gnt2;
    logic [5:0]  byteIdx,  byteIdx2;
    logic [3:0]  cellDone, cellDone2;
    logic [7:0]  txData,   txData2;
    logic        txSoc,    txSoc2;
    logic        txEnN,    txEnN2;
    logic [15:0] cellCnt;
    logic [1:0]  cellCnt2;

    int compared   = 0;
    int mismatched = 0;

    int  doneQ[$];
    bit  inCell   = 1'b0;
    int  pos      = 0;
    int  curPort  = 0;
    int  rrModel  = 3;
    int  expCnt   = 0;
    int  gap      = 1;
    logic [1:0] clavHist = '0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  en;
        int          nCells;
        logic [31:0] order;
    } vec_t;

    vec_t vecs[5];

    utopia1_tx_sched #(.N_PORTS(4), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .port_en(portEn),
        .cell_byte(cellByte), .gnt(gnt), .byte_idx(byteIdx),
        .cell_done(cellDone), .tx_data(txData), .tx_soc(txSoc),
        .tx_en_n(txEnN), .tx_clav(tx_clav), .cell_cnt(cellCnt)
    );

    utopia1_tx_sched #(.N_PORTS(4), .CNT_W(2)) dutWrap (
        .clk(clk), .reset_n(reset_n), .req(req), .port_en(portEn),
        .cell_byte(cellByte2), .gnt(gnt2), .byte_idx(byteIdx2),
        .cell_done(cellDone2), .tx_data(txData2), .tx_soc(txSoc2),
        .tx_en_n(txEnN2), .tx_clav(tx_clav), .cell_cnt(cellCnt2)
    );

    // Clock generation, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Source byte n of port p; lanes never collide between ports.
    function automatic logic [7:0] expByte(input int p, input int n);
        return 8'(n + 16 + 64 * p);
    endfunction

    function automatic int nextWinner(input int rr, input logic [3:0] elig);
        for (int k = 1; k <= 4; k++) begin
            if (elig[(rr + k) % 4]) return (rr + k) % 4;
        end
        return 15;
    endfunction

    function automatic logic [31:0] onehot(input int p);
        return (p < 4) ? (32'd1 << p) : 32'hDEAD;
    endfunction

    function automatic int decode(input logic [3:0] v);
        for (int p = 0; p < 4; p++) begin
            if (v == 4'(1 << p)) return p;
        end
        return 15;
    endfunction

    // Per-port cell buffers with an asynchronous read at byte_idx.
    always_comb begin
        cellByte  = '0;
        cellByte2 = '0;
        for (int p = 0; p < 4; p++) begin
            cellByte[8*p +: 8]  = expByte(p, int'(byteIdx));
            cellByte2[8*p +: 8] = expByte(p, int'(byteIdx2));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Clav history at rising edges; [1] is the value at the decision edge
    // when byte 0 is sampled on the following falling edge.
    always @(posedge clk) clavHist <= {clavHist[0], tx_clav};

    // Pin monitor: rebuilds cells and checks them against the cell-level model.
    always @(negedge clk) begin
        if (!reset_n) begin
            inCell  = 1'b0;
            pos     = 0;
            rrModel = 3;
            expCnt  = 0;
            gap     = 1;
        end else if (!txEnN) begin
            if (txSoc) begin
                if (inCell) checkOutput("cell length", pos, 53);
                inCell  = 1'b1;
                pos     = 0;
                curPort = nextWinner(rrModel, req & portEn);
                rrModel = curPort;
                checkOutput("gnt at soc", {28'b0, gnt}, onehot(curPort));
                checkOutput("idle gap", (gap >= 1) ? 1 : 0, 1);
                checkOutput("clav at decision", {31'b0, clavHist[1]}, 1);
            end
            if (inCell) begin
                checkOutput("tx_data", {24'b0, txData}, {24'b0, expByte(curPort, pos)});
                if (pos == 52) begin
                    checkOutput("cell_done", {28'b0, cellDone}, onehot(curPort));
                    expCnt++;
                    checkOutput("cell_cnt", {16'b0, cellCnt}, expCnt & 32'hFFFF);
                    checkOutput("cell_cnt wrap", {30'b0, cellCnt2}, expCnt % 4);
                    doneQ.push_back(decode(cellDone));
                    inCell = 1'b0;
                end else begin
                    checkOutput("cell_done early", {28'b0, cellDone}, 0);
                end
                pos++;
            end else begin
                checkOutput("stray byte soc", {31'b0, txSoc}, 1);
            end
            gap = 0;
        end else begin
            if (inCell) begin
                checkOutput("cell length", pos, 53);
                inCell = 1'b0;
            end
            checkOutput("soc while idle", {31'b0, txSoc}, 0);
            gap++;
        end
    end

    task automatic applyReset();
        reset_n = 1'b0;
        req     = '0;
        portEn  = '0;
        tx_clav = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset gnt",       {28'b0, gnt},      0);
        checkOutput("reset byte_idx",  {26'b0, byteIdx},  0);
        checkOutput("reset cell_done", {28'b0, cellDone}, 0);
        checkOutput("reset tx_data",   {24'b0, txData},   0);
        checkOutput("reset tx_soc",    {31'b0, txSoc},    0);
        checkOutput("reset tx_en_n",   {31'b0, txEnN},    1);
        checkOutput("reset cell_cnt",  {16'b0, cellCnt},  0);
        #2 reset_n = 1'b1;
    endtask

    task automatic waitCells(input int n, input int budget, input bit randClav);
        int cyc = 0;
        while (doneQ.size() < n && cyc < budget) begin
            @(negedge clk);
            #2;
            cyc++;
            if (randClav) tx_clav = 1'($urandom_range(0, 1));
        end
        if (doneQ.size() < n) checkOutput("cell wait timeout", doneQ.size(), n);
    endtask

    task automatic waitSoc(input int budget);
        int cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            #2;
            cyc++;
            seen = txSoc;
        end
        if (!seen) checkOutput("soc wait timeout", {31'b0, txSoc}, 1);
    endtask

    function automatic int doneAt(input int i);
        return (i < doneQ.size()) ? doneQ[i] : 15;
    endfunction

    task automatic applyStimulus(input int idx);
        applyReset();
        req     = vecs[idx].req;
        portEn  = vecs[idx].en;
        tx_clav = 1'b1;
        doneQ.delete();
        waitCells(vecs[idx].nCells, 1000, 1'b0);
        req = '0;
        repeat (3) @(negedge clk);
        #2;
        checkOutput($sformatf("cells served v%0d", idx), doneQ.size(), vecs[idx].nCells);
        checkOutput($sformatf("cell_cnt v%0d", idx), {16'b0, cellCnt}, vecs[idx].nCells);
        for (int i = 0; i < vecs[idx].nCells; i++) begin
            checkOutput($sformatf("grant order v%0d c%0d", idx, i), doneAt(i),
                        (vecs[idx].order >> (4 * i)) & 32'hF);
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{req: 4'b0001, en: 4'b1111, nCells: 1, order: 32'h0};
        vecs[1] = '{req: 4'b1111, en: 4'b1111, nCells: 8, order: 32'h3210_3210};
        vecs[2] = '{req: 4'b0110, en: 4'b1101, nCells: 3, order: 32'h222};
        vecs[3] = '{req: 4'b1010, en: 4'b1111, nCells: 4, order: 32'h3131};
        vecs[4] = '{req: 4'b1111, en: 4'b0101, nCells: 4, order: 32'h2020};

        for (int v = 0; v < 5; v++) applyStimulus(v);

        // Flow control: no cell while clav is low, byte 0 two edges after
        // clav rises, and a clav drop at byte 20 does not cut the cell.
        applyReset();
        req     = 4'b0010;
        portEn  = 4'b1111;
        tx_clav = 1'b0;
        doneQ.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            checkOutput("en_n while clav low", {31'b0, txEnN}, 1);
        end
        tx_clav = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("en_n after first clav edge", {31'b0, txEnN}, 1);
        @(posedge clk);
        #1;
        checkOutput("soc on second edge", {31'b0, txSoc}, 1);
        checkOutput("byte0 on second edge", {24'b0, txData}, 32'h50);
        repeat (20) @(posedge clk);
        #1;
        tx_clav = 1'b0;
        waitCells(1, 200, 1'b0);
        req = '0;
        checkOutput("clav drop port", doneAt(0), 1);

        // Request drop mid-cell still finishes the cell.
        applyReset();
        portEn  = 4'b1101;
        req     = 4'b0110;
        tx_clav = 1'b1;
        doneQ.delete();
        waitSoc(100);
        repeat (10) @(negedge clk);
        #2;
        req = '0;
        waitCells(1, 200, 1'b0);
        checkOutput("req drop port", doneAt(0), 2);
        repeat (5) @(negedge clk);
        #2;
        checkOutput("idle after req drop", {31'b0, txEnN}, 1);

        // Reset mid-cell: outputs clear without a clock, port 0 wins after.
        applyReset();
        portEn  = 4'b1111;
        req     = 4'b1111;
        tx_clav = 1'b1;
        doneQ.delete();
        waitCells(1, 200, 1'b0);
        waitSoc(100);
        repeat (30) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset tx_en_n",  {31'b0, txEnN},  1);
        checkOutput("async reset tx_soc",   {31'b0, txSoc},  0);
        checkOutput("async reset gnt",      {28'b0, gnt},    0);
        checkOutput("async reset cell_cnt", {16'b0, cellCnt}, 0);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        doneQ.delete();
        waitCells(1, 200, 1'b0);
        req = '0;
        checkOutput("first winner after reset", doneAt(0), 0);
        repeat (3) @(negedge clk);

        // Randomised batches against the monitor's round-robin model.
        applyReset();
        for (int b = 0; b < 12; b++) begin
            int n;
            #2;
            req    = 4'($urandom_range(0, 15));
            portEn = 4'($urandom_range(0, 15));
            n      = $urandom_range(1, 3);
            doneQ.delete();
            if ((req & portEn) == 4'b0000) begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    #2;
                    tx_clav = 1'($urandom_range(0, 1));
                end
                checkOutput("no eligible no cell", doneQ.size(), 0);
                checkOutput("no eligible en_n", {31'b0, txEnN}, 1);
            end else begin
                waitCells(n, 3000, 1'b1);
                req = '0;
                repeat (3) @(negedge clk);
                checkOutput("random cells served", doneQ.size(), n);
            end
            req = '0;
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
